// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with a registered 2-entry result FIFO,
// result flags and a wrap-around count of delivered results.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             y_zero,
    output logic             y_ones,
    output logic             y_parity,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASA = 3'b111
    } op_e;

    // Handshake rule on both ports: a transfer happens on a rising edge where
    // valid && ready; valid never depends on ready, and in_ready is a pure
    // register so out_ready has no combinational path to the input side.

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input op_e              sel
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            OP_PASA: r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign result = logic_op(A, B, op_e'(op));
    assign push   = in_valid && in_ready_q;
    assign pop    = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        txn_d      = txn_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            txn_d    = txn_q + CNT_W'(1);
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            txn_q      <= '0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= result;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            txn_q      <= txn_d;
        end
    end

    // An empty buffer presents zero so the flags describe a defined value.
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign Y         = out_valid ? slot_q[rd_ptr_q] : '0;
    assign y_zero    = (Y == '0);
    assign y_ones    = (Y == '1);
    assign y_parity  = ^Y;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: scoreboard queue fed by the driver,
// drained by a negedge monitor; directed cases plus a random stall run.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic [2:0] op_in = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y_out;
    logic       y_zero, y_ones, y_parity;
    logic [7:0] txn_count;

    logic       in2_valid = 1'b0;
    logic       in2_ready;
    logic [7:0] a2_in = 8'h5A;
    logic       out2_valid;
    logic       out2_ready = 1'b1;
    logic [7:0] y2_out;
    logic       y2_zero, y2_ones, y2_parity;
    logic [1:0] txn2_count;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         txn_model = 0;
    logic       held = 1'b0;
    logic [7:0] hold_y = 8'h00;
    logic       mon_en = 1'b1;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .op(op_in), .out_valid(out_valid), .out_ready(out_ready),
        .Y(y_out), .y_zero(y_zero), .y_ones(y_ones), .y_parity(y_parity),
        .txn_count(txn_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
        .A(a2_in), .B(8'h00), .op(3'b111), .out_valid(out2_valid), .out_ready(out2_ready),
        .Y(y2_out), .y_zero(y2_zero), .y_ones(y2_ones), .y_parity(y2_parity),
        .txn_count(txn2_count)
    );

    function automatic logic [7:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] o);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; records an expectation if the DUT will accept.
    task automatic cycle_drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] o, input logic ordy,
                               input logic use_exp, input logic [7:0] exp_y,
                               output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        a_in      = a;
        b_in      = b;
        op_in     = o;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) exp_q.push_back(use_exp ? exp_y : ref_model(a, b, o));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input logic ordy, input logic use_exp, input logic [7:0] exp_y);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) cycle_drive(1'b1, a, b, o, ordy, use_exp, exp_y, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle_drive(1'b0, 8'h00, 8'h00, 3'd0, ordy, 1'b0, 8'h00, acc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            idle(1'b1);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        idle(1'b1);
    endtask

    // Monitor: compares the head result on every output handshake.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (!out_valid) begin
                check("empty_y_zeroed", y_out, 0);
                held = 1'b0;
            end else begin
                if (held) check("stall_stable", y_out, hold_y);
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("spurious_output", 1, 0);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("result_y", y_out, e);
                        check("flag_zero", y_zero, (e == 8'h00));
                        check("flag_ones", y_ones, (e == 8'hFF));
                        check("flag_parity", y_parity, ($countones(e) % 2));
                        check("txn_count", txn_count, txn_model % 256);
                        txn_model++;
                    end
                end else begin
                    held   = 1'b1;
                    hold_y = y_out;
                end
            end
        end
    end

    initial begin : main
        logic [7:0] opcode_exp [8];
        logic [1:0] wrap_exp [5];
        logic       acc;
        opcode_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        wrap_exp   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_y", y_out, 0);
        check("rst_y_zero", y_zero, 1);
        check("rst_y_ones", y_ones, 0);
        check("rst_y_parity", y_parity, 0);
        check("rst_txn", txn_count, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // All eight opcodes back to back with out_ready high
        for (int i = 0; i < 8; i++) begin
            send(8'hF0, 8'h3C, 3'(i), 1'b1, 1'b1, opcode_exp[i]);
            if (i == 0) check("latency_before_accept", out_valid, 0);
            if (i == 1) check("latency_one_cycle", out_valid, 1);
        end
        drain();
        check("txn_after_opcodes", txn_count, 8);

        // Backpressure: fill both slots, third request must stall
        send(8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1, 8'hFF);
        send(8'hAA, 8'h55, 3'd2, 1'b0, 1'b1, 8'hFF);
        idle(1'b0);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head_ones", y_ones, 1);
        for (int i = 0; i < 2; i++) begin
            cycle_drive(1'b1, 8'h12, 8'h34, 3'd1, 1'b0, 1'b0, 8'h00, acc);
            check("full_third_blocked", acc, 0);
        end
        cycle_drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, acc);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_pop", in_ready, 1);
        drain();

        // Flag corner values
        send(8'hFF, 8'hFF, 3'd3, 1'b1, 1'b1, 8'h00);
        send(8'h01, 8'h00, 3'd1, 1'b1, 1'b1, 8'h01);
        drain();

        // Asynchronous reset while the buffer is full
        send(8'h0F, 8'h0F, 3'd1, 1'b0, 1'b0, 8'h00);
        send(8'h33, 8'h0F, 3'd2, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y_out, 0);
        check("midrst_txn", txn_count, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        txn_model = 0;
        held      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("midrst_ignore_input", out_valid, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        mon_en   = 1'b1;
        send(8'hC3, 8'h0F, 3'd5, 1'b1, 1'b1, 8'h33);
        drain();

        // Random valid/ready stall traffic
        for (int c = 0; c < 1000; c++) begin
            cycle_drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        1'b0, 8'h00, acc);
        end
        drain();

        // Counter wrap on the CNT_W=2 instance
        @(posedge clk);
        #1 in2_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            if (i == 3) #1 in2_valid = 1'b0;
            @(negedge clk);
            check("wrap_txn", txn2_count, wrap_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit gate primitives: WIDTH-bit bitwise logic unit, eight operations selected per transaction by opcode.
- Results pass through a 2-entry output buffer with valid/ready handshakes on both sides, so the block can sit in a streaming datapath.
- Provides zero, all-ones and parity flags on the result, plus a wrap-around count of completed transactions.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 8, width of completed-transaction counter (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept a transaction
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  3  operation select
- out_valid  output  1  result at buffer head valid
- out_ready  input  1  downstream accepts result
- Y  output  WIDTH  result at buffer head
- y_zero  output  1  Y == 0
- y_ones  output  1  Y == all ones
- y_parity  output  1  XOR-reduction of Y
- txn_count  output  CNT_W  number of output handshakes completed, modulo 2^CNT_W

Behaviour:
- Opcode encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND
  - 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A
  - All operations are bitwise over WIDTH bits.
- Reset (async assert, sync-safe deassert):
  - Buffer empty (count=0), out_valid=0, in_ready=1.
  - Y=0, y_zero=1, y_ones=0, y_parity=0, txn_count=0.
  - Storage slots cleared to 0.
- Handshakes:
  - Input accepted on a rising edge with in_valid && in_ready.
  - Output consumed on a rising edge with out_valid && out_ready.
- Result computation and storage:
  - The result is computed combinationally from A/B/op and written into the buffer at the accept edge.
  - Latency is 1 cycle: out_valid goes high in the cycle after accept when the buffer was empty.
- Buffer:
  - 2-entry FIFO; count is in 0..2, registered.
  - in_ready = (count != 2). This is a registered decode with no combinational path from out_ready.
  - out_valid = (count != 0).
- Count updates on each edge:
  - push only: count+1
  - pop only: count-1
  - push and pop together (count=1): count unchanged; new result enters, old head leaves
  - Full (count=2): in_ready=0, so no push occurs even if a pop happens the same edge. A pop from full gives count=1, and in_ready=1 in the next cycle.
- Ordering: results leave in strict acceptance order.
- Throughput: with out_ready held high, one transaction per cycle is sustained (count stays at 1).
- Output stability:
  - While out_valid=1 and out_ready=0, Y and the flags hold stable.
  - in_valid with in_ready=0 has no effect.
- Output when empty: when out_valid=0, Y is forced to 0 and the flags follow that value.
- Flags: combinational from the Y port value.
- txn_count: increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - Buffered results are discarded and txn_count clears immediately on rst_n low.
  - Inputs presented during reset are ignored.
- op values are sampled only at the accept edge. Changing op while not accepted has no effect.

Test Plan:
- WIDTH=8, out_ready=1. Send A=8'hF0, B=8'h3C with op 000..111 on consecutive cycles.
  - Required Y: 30, FC, CC, CF, 03, 33, 0F, F0, one per cycle, each 1 cycle after accept.
  - txn_count=8 at the end.
  - y_zero, y_ones and y_parity are correct at each result.
- Backpressure: out_ready=0; send AND(FF,FF), then XOR(AA,55).
  - Required: count reaches 2 and in_ready=0.
  - A third in_valid is not accepted.
  - Then out_ready=1: Y=FF (y_ones=1) followed by FF; in_ready returns to 1 one cycle after the first pop.
- Flags: NAND(FF,FF) -> Y=00, y_zero=1, y_parity=0. OR(01,00) -> Y=01, y_parity=1.
- Reset mid-stream: buffer holds 2 results; pull rst_n low between edges.
  - Required: out_valid=0, Y=0 and txn_count=0 immediately, without waiting for a clock edge.
  - After release, the first accepted transaction emerges correctly.
- Counter wrap: CNT_W=2; complete 5 output handshakes -> txn_count sequence 1, 2, 3, 0, 1.
- Random stall: random in_valid/out_ready for 1000 cycles against a scoreboard.
  - Required: no lost, duplicated or reordered results.
  - Y is stable whenever stalled.
